// File: rtl/mem_access_unit.sv
// Memory-stage controller: issues loads/stores over a req/ack handshake, stalls upstream while busy,
// times out hung accesses and registers results toward MEM/WB.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  rd_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        mem_fault,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_is_load;
    logic [4:0]    r_rd;
    logic          r_reg_write;
    logic          r_mem_to_reg;
    logic          w_mem_op;
    logic          w_timeout;

    assign w_mem_op  = mem_read_in | mem_write_in;
    assign w_timeout = (r_state == ACCESS) && !dmem_ack && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    stall  = 1'b1;
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (dmem_ack || w_timeout) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            mem_fault      <= 1'b0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            r_cnt          <= '0;
            r_is_load      <= 1'b0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        // Store wins when both read and write are set.
                        dmem_req       <= 1'b1;
                        dmem_we        <= mem_write_in;
                        dmem_addr      <= alu_result_in;
                        dmem_wdata     <= write_data_in;
                        r_cnt          <= '0;
                        r_is_load      <= !mem_write_in;
                        r_rd           <= rd_in;
                        r_reg_write    <= reg_write_in;
                        r_mem_to_reg   <= mem_to_reg_in;
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= 1'b0;
                    end else begin
                        alu_result_out <= alu_result_in;
                        rd_out         <= rd_in;
                        reg_write_out  <= reg_write_in;
                        mem_to_reg_out <= mem_to_reg_in;
                    end
                end
                ACCESS: begin
                    reg_write_out  <= 1'b0;
                    mem_to_reg_out <= 1'b0;
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (r_is_load) read_data_out <= dmem_rdata;
                    end else if (w_timeout) begin
                        dmem_req  <= 1'b0;
                        mem_fault <= 1'b1;
                    end else if (r_cnt != CW'(TIMEOUT)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    // mem_fault is still high here only if the access timed out.
                    alu_result_out <= dmem_addr;
                    rd_out         <= r_rd;
                    reg_write_out  <= r_reg_write & !mem_fault;
                    mem_to_reg_out <= r_mem_to_reg;
                    if (mem_fault) read_data_out <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, load/store latency, timeout, reset, back-to-back ops.
module tb_mem_access_unit;
    logic        clk;
    logic        reset;
    logic [31:0] alu_result_in;
    logic [31:0] write_data_in;
    logic [4:0]  rd_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        mem_fault;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;

    int n_checks = 0;
    int n_fail   = 0;

    int          n_stall, n_req, n_fault, n_bub, n_done;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in), .rd_in(rd_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .mem_fault(mem_fault),
        .read_data_out(read_data_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic rd_b, input logic wr_b, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic rw, input logic m2r);
        mem_read_in   = rd_b;
        mem_write_in  = wr_b;
        alu_result_in = addr;
        write_data_in = wdata;
        rd_in         = rd;
        reg_write_in  = rw;
        mem_to_reg_in = m2r;
    endtask

    task automatic set_nop();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    // Runs one memory op already applied on the inputs; acks on the ack_at-th request cycle
    // (0 = never). Returns just after the edge that leaves DONE.
    task automatic run_mem(input int ack_at, input logic [31:0] rdata, input logic spur);
        n_stall = 0; n_req = 0; n_fault = 0; n_bub = 0; n_done = 0;
        for (int c = 0; c < 20 && n_done == 0; c++) begin
            #1;
            if (stall) n_stall++;
            if (mem_fault) n_fault++;
            dmem_ack = 1'b0;
            if (dmem_req) begin
                n_req++;
                s_we = dmem_we; s_addr = dmem_addr; s_wdata = dmem_wdata;
                if (reg_write_out || mem_to_reg_out) n_bub++;
                if (n_req == ack_at) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end else if (!stall && n_stall > 0) begin
                n_done = 1;
                dmem_ack   = spur;
                dmem_rdata = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        set_nop();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fault", mem_fault, 0);
        chk("rst_alu", alu_result_out, 0);
        chk("rst_rdata", read_data_out, 0);
        chk("rst_rw", reg_write_out, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU op passes straight through
        set_in(1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
        #1;
        chk("alu_stall", stall, 0);
        @(posedge clk); #1;
        chk("alu_res", alu_result_out, 32'h1234);
        chk("alu_rd", rd_out, 5);
        chk("alu_rw", reg_write_out, 1);

        // Load acked on 3rd ACCESS cycle
        set_in(1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1);
        run_mem(3, 32'hDEAD_BEEF, 1'b0);
        chk("ld_done", n_done, 1);
        chk("ld_stall", n_stall, 4);
        chk("ld_req", n_req, 3);
        chk("ld_we", s_we, 0);
        chk("ld_addr", s_addr, 32'h100);
        chk("ld_bubble", n_bub, 0);
        chk("ld_rdata", read_data_out, 32'hDEAD_BEEF);
        chk("ld_m2r", mem_to_reg_out, 1);
        chk("ld_rw", reg_write_out, 1);
        chk("ld_rd", rd_out, 7);
        chk("ld_alu", alu_result_out, 32'h100);

        // ALU op to leave reg_write_out high, then store with immediate ack
        set_in(1'b0, 1'b0, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("pre_st_rw", reg_write_out, 1);
        set_in(1'b0, 1'b1, 32'h200, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0);
        run_mem(1, 32'h0, 1'b0);
        chk("st_done", n_done, 1);
        chk("st_req", n_req, 1);
        chk("st_we", s_we, 1);
        chk("st_addr", s_addr, 32'h200);
        chk("st_wdata", s_wdata, 32'hA5A5_A5A5);
        chk("st_stall", n_stall, 2);
        chk("st_bubble", n_bub, 0);
        chk("st_rw", reg_write_out, 0);
        chk("st_rdata_hold", read_data_out, 32'hDEAD_BEEF);

        // Load never acked: times out after 4 request cycles, spurious ack in DONE ignored
        set_in(1'b1, 1'b0, 32'h400, 32'h0, 5'd9, 1'b1, 1'b1);
        run_mem(0, 32'h0, 1'b1);
        chk("to_done", n_done, 1);
        chk("to_req", n_req, 4);
        chk("to_stall", n_stall, 5);
        chk("to_fault", n_fault, 1);
        chk("to_rw", reg_write_out, 0);
        chk("to_rdata", read_data_out, 0);
        chk("to_fault_clr", mem_fault, 0);
        set_nop();
        @(posedge clk); #1;
        chk("to_spur_req", dmem_req, 0);
        chk("to_spur_rdata", read_data_out, 0);

        // Reset asserted mid-access with an ack pending
        set_in(1'b0, 1'b0, 32'h77, 32'h0, 5'd4, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_in(1'b1, 1'b0, 32'h300, 32'h0, 5'd6, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("ra_req_pre", dmem_req, 1);
        reset = 1'b0;
        set_nop();
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("ra_req", dmem_req, 0);
        chk("ra_stall", stall, 0);
        chk("ra_alu", alu_result_out, 0);
        chk("ra_rd", rd_out, 0);
        chk("ra_rw", reg_write_out, 0);
        chk("ra_rdata", read_data_out, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        set_in(1'b1, 1'b0, 32'h300, 32'h0, 5'd6, 1'b1, 1'b1);
        run_mem(2, 32'h0BAD_F00D, 1'b0);
        chk("ra_ld_req", n_req, 2);
        chk("ra_ld_rdata", read_data_out, 32'h0BAD_F00D);
        chk("ra_ld_rw", reg_write_out, 1);

        // Back-to-back load then store, second op applied right after DONE
        set_in(1'b1, 1'b0, 32'h500, 32'h0, 5'd10, 1'b1, 1'b1);
        run_mem(1, 32'hCAFE_0001, 1'b0);
        chk("bb1_req", n_req, 1);
        chk("bb1_we", s_we, 0);
        chk("bb1_addr", s_addr, 32'h500);
        chk("bb1_rdata", read_data_out, 32'hCAFE_0001);
        set_in(1'b0, 1'b1, 32'h600, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
        run_mem(1, 32'h0, 1'b0);
        chk("bb2_req", n_req, 1);
        chk("bb2_stall", n_stall, 2);
        chk("bb2_we", s_we, 1);
        chk("bb2_addr", s_addr, 32'h600);
        chk("bb2_wdata", s_wdata, 32'h1234_5678);
        set_nop();
        #1;
        chk("bb_idle_stall", stall, 0);
        @(posedge clk); #1;
        chk("bb_no_dup_req", dmem_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller that consumes the EX/MEM pipeline register outputs and performs loads and stores over a variable-latency data-memory handshake. It stalls the upstream pipeline while an access is outstanding, times out hung accesses, and registers the results toward the MEM/WB boundary. It sits between the EX/MEM register and the write-back stage.

## Interface
- TIMEOUT, 255: maximum ACCESS cycles to wait for `dmem_ack` (range 1..65535).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`; 0 = reset.
- alu_result_in  in  32  effective address for memory ops; pass-through value for ALU ops.
- write_data_in  in  32  store data.
- rd_in  in  5  destination register.
- mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in  in  1 each  control bits from EX/MEM.
- dmem_req  out  1  access request, held until `dmem_ack` or timeout.
- dmem_we  out  1  1 = store, 0 = load; valid while `dmem_req`.
- dmem_addr  out  32  access address; valid while `dmem_req`.
- dmem_wdata  out  32  store data; valid while `dmem_req`.
- dmem_rdata  in  32  load data; valid when `dmem_ack`.
- dmem_ack  in  1  one-cycle completion from memory.
- stall  out  1  combinational: hold EX/MEM and earlier stages.
- mem_fault  out  1  one-cycle pulse: access timed out.
- read_data_out, alu_result_out  out  32 each  to MEM/WB.
- rd_out  out  5  to MEM/WB.
- reg_write_out, mem_to_reg_out  out  1 each  to MEM/WB.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state: IDLE.
- IDLE:
  - No memory op (`mem_read_in`=0, `mem_write_in`=0): `stall`=0. The WB registers capture `alu_result_in`, `rd_in`, `reg_write_in` and `mem_to_reg_in`, and `read_data_out` holds.
  - Memory op: `stall`=1, and the address, data and `we` are latched into the `dmem_*` registers.
    - `dmem_we` = `mem_write_in`. A store has priority if both read and write are set.
    - `dmem_req` is set to 1 at the next edge, and the FSM moves to ACCESS with the timeout counter cleared.
- ACCESS:
  - `stall`=1. `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` are stable.
  - The counter increments each cycle without `dmem_ack`.
  - On `dmem_ack`: load data is captured from `dmem_rdata` (stores leave `read_data_out` unchanged), `dmem_req` drops at the same edge, and the FSM moves to DONE.
  - When the counter reaches TIMEOUT without an ack: `dmem_req` drops, the fault flag is set, and the FSM moves to DONE.
- DONE:
  - `stall`=0.
  - At the edge leaving DONE, the WB registers capture the instruction. On a fault, `reg_write_out` is forced to 0 and `read_data_out` is set to 0.
  - The FSM returns to IDLE unconditionally. The same instruction is never reissued.
- Bubbles: at every edge where `stall`=1, `reg_write_out` and `mem_to_reg_out` are loaded with 0. `alu_result_out` and `rd_out` hold.
- `dmem_ack` is ignored outside ACCESS.
- The counter is `$clog2(TIMEOUT+1)` bits wide and saturates. It never wraps.

## Timing
- Reset values: every output is 0, and the FSM is in IDLE.
- Reset mid-access: `dmem_req` is 0 after the reset edge, and a pending ack is dropped.
- Non-memory op: WB outputs update at the next edge (latency 1), with no stall.
- Memory op, ack on the first ACCESS cycle:
  - Edge 1: IDLE→ACCESS.
  - Edge 2: ACCESS→DONE.
  - Edge 3: WB outputs update.
  - `stall` is high for 2 cycles.
- Each additional wait cycle adds 1 stall cycle.
- Timeout: `dmem_req` is high for exactly TIMEOUT cycles. `mem_fault` is high only during the DONE cycle.
- Back-to-back memory ops: the second op is seen in IDLE on the cycle after DONE. There is no idle gap beyond that.

## Test plan
- ALU op (`mem_read`=`mem_write`=0, `alu_result`=0x1234, `rd`=5, `reg_write`=1) → next edge: `alu_result_out`=0x1234, `rd_out`=5, `reg_write_out`=1; `stall` never asserted.
- Load, addr 0x100, memory acks on the 3rd ACCESS cycle with `rdata`=0xDEADBEEF → `stall` high 4 cycles; `dmem_req` high 3 cycles, `dmem_we`=0, `dmem_addr`=0x100; then `read_data_out`=0xDEADBEEF, `mem_to_reg_out`=1, `reg_write_out`=1.
- Store, addr 0x200, data 0xA5A5A5A5, immediate ack → `dmem_we`=1, `dmem_wdata`=0xA5A5A5A5 for 1 cycle; `stall` high 2 cycles; `reg_write_out`=0; bubbles while stalled.
- TIMEOUT=4, load never acked → `dmem_req` high exactly 4 cycles; `mem_fault` pulses 1 cycle; `reg_write_out`=0, `read_data_out`=0; a spurious ack the following cycle is ignored.
- Reset low during ACCESS → after the edge, `dmem_req`=0, `stall`=0 and all WB outputs are 0; a subsequent load completes normally.
- Back-to-back load then store, both immediate ack → exactly 2 `dmem_req` pulses with correct `we`/addr ordering; no duplicate request for either op.
